blake2_io_intf_p: RTL and testbench

- Parametrised successor to the byte-serial host interface of the BLAKE2 hasher; supports both BLAKE2s (64-byte blocks) and BLAKE2b (128-byte blocks).
- Sits between the 8-bit pin-level command bus and the hash engine.
- Collects the configuration (kk, nn, ll) and streams message bytes to the engine with block index and first/last flags.
- Adds three behaviours the previous interface lacked: engine back-pressure, automatic zero padding of the final block, and output of the nn-byte digest.

---
 rtl/blake2_io_intf_p_if.sv | 37 +++
 rtl/blake2_io_intf_p.sv | 176 +++++++++++++++++
 tb/tb_blake2_io_intf_p.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/blake2_io_intf_p_if.sv
// Host byte bus and hash-engine stream of the BLAKE2 host interface.
// Latency: none (wires only).
// Backpressure: ready_o / engine_ready_i travel through this bundle.
interface blake2_io_intf_p_if #(
    parameter int LL_W  = 64,
    parameter int IDX_W = 6
);
    logic              valid_i;
    logic [1:0]        cmd_i;
    logic [7:0]        data_i;
    logic              ready_o;
    logic              hash_finished_o;
    logic [7:0]        hash_o;
    logic              engine_ready_i;
    logic              hash_finished_i;
    logic [7:0]        hash_i;
    logic [6:0]        kk_o;
    logic [6:0]        nn_o;
    logic [LL_W-1:0]   ll_o;
    logic              data_v_o;
    logic [7:0]        data_o;
    logic [IDX_W-1:0]  data_idx_o;
    logic              block_first_o;
    logic              block_last_o;

    modport slave (
        input  valid_i, cmd_i, data_i, engine_ready_i, hash_finished_i, hash_i,
        output ready_o, hash_finished_o, hash_o, kk_o, nn_o, ll_o,
               data_v_o, data_o, data_idx_o, block_first_o, block_last_o
    );

    modport master (
        output valid_i, cmd_i, data_i, engine_ready_i, hash_finished_i, hash_i,
        input  ready_o, hash_finished_o, hash_o, kk_o, nn_o, ll_o,
               data_v_o, data_o, data_idx_o, block_first_o, block_last_o
    );
endinterface

// File: rtl/blake2_io_intf_p.sv
// Host interface for BLAKE2s/b: collects kk/nn/ll, streams padded blocks, returns digest.
// Latency: 1 cycle host byte -> engine byte, 1 cycle engine digest -> hash_o.
// Backpressure: ready_o mirrors engine_ready_i in DATA; pad bytes wait for engine_ready_i.
module blake2_io_intf_p #(
    parameter int BB    = 64,
    parameter int LL_W  = 64,
    parameter int IDX_W = $clog2(BB)
) (
    input  logic              clk,
    input  logic              nreset,
    blake2_io_intf_p_if.slave bus
);
    localparam int LL_B   = LL_W / 8;
    localparam int CONF_N = 2 + LL_B;
    localparam int CNT_W  = $clog2(CONF_N + 1);

    localparam logic [1:0] CMD_CONF  = 2'd0;
    localparam logic [1:0] CMD_START = 2'd1;
    localparam logic [1:0] CMD_DATA  = 2'd2;
    localparam logic [1:0] CMD_ABORT = 2'd3;

    typedef enum logic [2:0] {IDLE, CONF, DATA, PAD, WAIT_HASH, OUT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] conf_cnt;
    logic [LL_W:0]    remain;
    logic [IDX_W-1:0] idx;
    logic             first_blk;
    logic             last_blk;
    logic [6:0]       out_cnt;

    logic             is_conf, is_start, is_abort, xfer, start_ok;
    logic             last_idx, cur_last, out_done;
    logic [LL_W:0]    total;

    assign is_conf  = bus.valid_i && (bus.cmd_i == CMD_CONF);
    assign is_start = bus.valid_i && (bus.cmd_i == CMD_START);
    assign is_abort = bus.valid_i && (bus.cmd_i == CMD_ABORT);

    assign bus.ready_o = (state == DATA) && bus.engine_ready_i;
    assign xfer        = bus.valid_i && (bus.cmd_i == CMD_DATA) && bus.ready_o;

    // Keyed hashes prepend one full key block to the message.
    assign total    = {1'b0, bus.ll_o} + ((bus.kk_o != 7'd0) ? (LL_W+1)'(BB) : '0);
    assign start_ok = (state == CONF) && is_start && (conf_cnt == CNT_W'(CONF_N));
    assign last_idx = (idx == IDX_W'(BB - 1));
    // A block is the last one when no more than BB bytes remain at its first byte.
    assign cur_last = (idx == '0) ? (remain <= (LL_W+1)'(BB)) : last_blk;
    assign out_done = ({1'b0, out_cnt} + 8'd1) >= {1'b0, bus.nn_o};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (is_conf) state_nxt = CONF;
            CONF:      if (start_ok) state_nxt = (total == '0) ? PAD : DATA;
            DATA:      if (xfer && (remain == (LL_W+1)'(1))) state_nxt = last_idx ? WAIT_HASH : PAD;
            PAD:       if (bus.engine_ready_i && last_idx) state_nxt = WAIT_HASH;
            WAIT_HASH: if (bus.hash_finished_i) state_nxt = (bus.nn_o <= 7'd1) ? IDLE : OUT;
            OUT:       if (out_done) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        if (is_abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            conf_cnt              <= '0;
            remain                <= '0;
            idx                   <= '0;
            first_blk             <= 1'b0;
            last_blk              <= 1'b0;
            out_cnt               <= '0;
            bus.kk_o              <= '0;
            bus.nn_o              <= '0;
            bus.ll_o              <= '0;
            bus.data_v_o          <= 1'b0;
            bus.data_o            <= '0;
            bus.data_idx_o        <= '0;
            bus.block_first_o     <= 1'b0;
            bus.block_last_o      <= 1'b0;
            bus.hash_finished_o   <= 1'b0;
            bus.hash_o            <= '0;
        end else begin
            bus.data_v_o        <= 1'b0;
            bus.data_o          <= '0;
            bus.data_idx_o      <= '0;
            bus.block_first_o   <= 1'b0;
            bus.block_last_o    <= 1'b0;
            bus.hash_finished_o <= 1'b0;
            bus.hash_o          <= '0;

            case (state)
                IDLE, CONF: begin
                    if (is_conf && (conf_cnt < CNT_W'(CONF_N))) begin
                        conf_cnt <= conf_cnt + 1'b1;
                        if (conf_cnt == CNT_W'(0)) bus.kk_o <= bus.data_i[6:0];
                        if (conf_cnt == CNT_W'(1)) bus.nn_o <= bus.data_i[6:0];
                        for (int b = 0; b < LL_B; b++) begin
                            if (conf_cnt == CNT_W'(b + 2)) bus.ll_o[8*b +: 8] <= bus.data_i;
                        end
                    end
                    if (start_ok) begin
                        conf_cnt  <= '0;
                        remain    <= total;
                        idx       <= '0;
                        first_blk <= 1'b1;
                        last_blk  <= 1'b0;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        bus.data_v_o      <= 1'b1;
                        bus.data_o        <= bus.data_i;
                        bus.data_idx_o    <= idx;
                        bus.block_first_o <= first_blk;
                        bus.block_last_o  <= cur_last;
                        last_blk          <= cur_last;
                        remain            <= remain - 1'b1;
                        idx               <= idx + 1'b1;
                        if (last_idx) first_blk <= 1'b0;
                    end
                end
                PAD: begin
                    // Padding always completes the final block.
                    if (bus.engine_ready_i) begin
                        bus.data_v_o      <= 1'b1;
                        bus.data_idx_o    <= idx;
                        bus.block_first_o <= first_blk;
                        bus.block_last_o  <= 1'b1;
                        idx               <= idx + 1'b1;
                    end
                end
                WAIT_HASH: begin
                    if (bus.hash_finished_i) begin
                        bus.hash_finished_o <= 1'b1;
                        bus.hash_o          <= bus.hash_i;
                        out_cnt             <= 7'd1;
                    end
                end
                OUT: begin
                    bus.hash_finished_o <= bus.hash_finished_i;
                    bus.hash_o          <= bus.hash_i;
                    out_cnt             <= out_cnt + 1'b1;
                end
                default: ;
            endcase

            if (is_abort) begin
                conf_cnt            <= '0;
                remain              <= '0;
                idx                 <= '0;
                first_blk           <= 1'b0;
                last_blk            <= 1'b0;
                out_cnt             <= '0;
                bus.kk_o            <= '0;
                bus.nn_o            <= '0;
                bus.ll_o            <= '0;
                bus.data_v_o        <= 1'b0;
                bus.data_o          <= '0;
                bus.data_idx_o      <= '0;
                bus.block_first_o   <= 1'b0;
                bus.block_last_o    <= 1'b0;
                bus.hash_finished_o <= 1'b0;
                bus.hash_o          <= '0;
            end
        end
    end
endmodule

// File: tb/tb_blake2_io_intf_p.sv
// Bench for blake2_io_intf_p: one BLAKE2s-sized and one BLAKE2b-sized instance, shared host driver.
module tb_blake2_io_intf_p;
    localparam logic [1:0] C_CONF = 2'd0, C_START = 2'd1, C_DATA = 2'd2, C_ABORT = 2'd3;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    logic       sel, valid, eng_rdy, hf;
    logic [1:0] cmd;
    logic [7:0] din, hin;

    blake2_io_intf_p_if #(.LL_W(64),  .IDX_W(6)) if_s ();
    blake2_io_intf_p_if #(.LL_W(128), .IDX_W(7)) if_b ();

    blake2_io_intf_p #(.BB(64),  .LL_W(64))  dut_s (.clk(clk), .nreset(nreset), .bus(if_s.slave));
    blake2_io_intf_p #(.BB(128), .LL_W(128)) dut_b (.clk(clk), .nreset(nreset), .bus(if_b.slave));

    assign if_s.valid_i = valid & ~sel;
    assign if_b.valid_i = valid & sel;
    assign if_s.cmd_i = cmd;
    assign if_b.cmd_i = cmd;
    assign if_s.data_i = din;
    assign if_b.data_i = din;
    assign if_s.engine_ready_i = eng_rdy;
    assign if_b.engine_ready_i = eng_rdy;
    assign if_s.hash_finished_i = hf & ~sel;
    assign if_b.hash_finished_i = hf & sel;
    assign if_s.hash_i = hin;
    assign if_b.hash_i = hin;

    logic         rdy_m, dv_m, first_m, last_m, hfo_m;
    logic [7:0]   d_m, h_m;
    logic [6:0]   idx_m, kk_m, nn_m;
    logic [127:0] ll_m;
    assign rdy_m   = sel ? if_b.ready_o         : if_s.ready_o;
    assign dv_m    = sel ? if_b.data_v_o        : if_s.data_v_o;
    assign first_m = sel ? if_b.block_first_o   : if_s.block_first_o;
    assign last_m  = sel ? if_b.block_last_o    : if_s.block_last_o;
    assign hfo_m   = sel ? if_b.hash_finished_o : if_s.hash_finished_o;
    assign d_m     = sel ? if_b.data_o          : if_s.data_o;
    assign h_m     = sel ? if_b.hash_o          : if_s.hash_o;
    assign idx_m   = sel ? if_b.data_idx_o      : {1'b0, if_s.data_idx_o};
    assign kk_m    = sel ? if_b.kk_o            : if_s.kk_o;
    assign nn_m    = sel ? if_b.nn_o            : if_s.nn_o;
    assign ll_m    = sel ? if_b.ll_o            : {64'd0, if_s.ll_o};

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected engine stream: every byte of every block, zero beyond T.
    typedef struct {
        logic [7:0] d;
        int         idx;
        bit         first;
        bit         last;
    } rec_t;
    rec_t exp_q[$];
    int   pulse_cnt;

    always @(negedge clk) begin
        if (nreset && dv_m) begin
            rec_t r;
            if (exp_q.size() == 0) begin
                chk("unexpected_data_v", 1, 0);
            end else begin
                r = exp_q.pop_front();
                chk("data_o", d_m, r.d);
                chk("data_idx_o", idx_m, r.idx);
                chk("block_first_o", first_m, r.first);
                chk("block_last_o", last_m, r.last);
            end
            pulse_cnt++;
        end
    end

    task automatic drive(input logic v, input logic [1:0] c, input logic [7:0] d);
        @(negedge clk);
        valid = v;
        cmd   = c;
        din   = d;
    endtask

    // stop_mode: 0 full run, 1 ABORT after stop_at accepted bytes, 2 reset pulse in WAIT_HASH
    task automatic run_session(input int s, input int kk, input int nn, input int ll, input int mode,
                               input bit early, input int stop_mode, input int stop_at,
                               output int pulses, output int acc, output int model_n);
        int           bb, conf_n, total, nblk, cyc;
        logic [127:0] llv;
        logic [7:0]   cb;
        logic [7:0]   msg[];
        logic [7:0]   hb[];
        sel     = (s != 0);
        eng_rdy = 1'b1;
        bb      = s ? 128 : 64;
        conf_n  = s ? 18 : 10;
        llv     = 128'(ll);
        total   = ll + ((kk != 0) ? bb : 0);
        msg     = new[(total > 0) ? total : 1];
        foreach (msg[i]) msg[i] = 8'($urandom);
        nblk    = (total == 0) ? 1 : (total + bb - 1) / bb;
        exp_q.delete();
        for (int i = 0; i < nblk * bb; i++) begin
            rec_t r;
            r.d     = (i < total) ? msg[i] : 8'h00;
            r.idx   = i % bb;
            r.first = (i / bb) == 0;
            r.last  = (i / bb) == nblk - 1;
            exp_q.push_back(r);
        end
        model_n   = nblk * bb;
        pulse_cnt = 0;
        acc       = 0;

        for (int i = 0; i < conf_n; i++) begin
            cb = (i == 0) ? 8'(kk) : (i == 1) ? 8'(nn) : llv[8*(i-2) +: 8];
            drive(1'b1, C_CONF, cb);
            if (early && i == 4) begin
                drive(1'b1, C_START, 8'h00);
                for (int j = 0; j < 3; j++) begin
                    drive(1'b1, C_DATA, 8'h5A);
                    #1;
                    chk("early_start_ready", rdy_m, 0);
                    chk("early_start_data_v", dv_m, 0);
                end
            end
        end
        drive(1'b0, C_CONF, 8'h00);
        #1;
        chk("kk_o", kk_m, kk);
        chk("nn_o", nn_m, nn);
        chk("ll_o", ll_m, llv);
        drive(1'b1, C_START, 8'h00);

        cyc = 0;
        while (exp_q.size() > 0 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            case (mode)
                1:       eng_rdy = (cyc % 2) == 1;
                2:       eng_rdy = 1'($urandom_range(0, 1));
                default: eng_rdy = 1'b1;
            endcase
            if (stop_mode == 1 && acc == stop_at) begin
                valid = 1'b1; cmd = C_ABORT; din = 8'h00;
                @(negedge clk);
                valid = 1'b0;
                #1;
                chk("abort_data_v", dv_m, 0);
                chk("abort_ready", rdy_m, 0);
                chk("abort_kk", kk_m, 0);
                chk("abort_nn", nn_m, 0);
                chk("abort_ll", ll_m, 0);
                exp_q.delete();
                pulses = pulse_cnt;
                return;
            end else if (acc < total) begin
                valid = 1'b1; cmd = C_DATA; din = msg[acc];
            end else begin
                valid = 1'($urandom_range(0, 1)); cmd = C_DATA; din = 8'hA5;
            end
            #1;
            chk("ready_o", rdy_m, eng_rdy && (acc < total));
            if (valid && cmd == C_DATA && rdy_m && acc < total) acc++;
        end
        if (exp_q.size() > 0) chk("data_phase_timeout", exp_q.size(), 0);
        valid   = 1'b0;
        eng_rdy = 1'b1;
        repeat (2) @(negedge clk);

        if (stop_mode == 2) begin
            #2 nreset = 1'b0;
            #1;
            chk("rst_data_v", dv_m, 0);
            chk("rst_hash_finished", hfo_m, 0);
            chk("rst_kk", kk_m, 0);
            chk("rst_nn", nn_m, 0);
            chk("rst_ll", ll_m, 0);
            chk("rst_flags", {first_m, last_m}, 0);
            @(negedge clk);
            nreset = 1'b1;
            pulses = pulse_cnt;
            return;
        end

        hb = new[nn];
        for (int j = 0; j <= nn; j++) begin
            @(negedge clk);
            if (j == 0) begin
                chk("hash_early", hfo_m, 0);
            end else begin
                chk("hash_finished_o", hfo_m, 1);
                chk("hash_o", h_m, hb[j-1]);
            end
            if (j < nn) begin
                hb[j] = 8'($urandom);
                hf = 1'b1; hin = hb[j];
            end else begin
                hf = 1'b0; hin = 8'h00;
            end
        end
        @(negedge clk);
        chk("hash_finished_o_end", hfo_m, 0);
        pulses = pulse_cnt;
    endtask

    typedef struct {
        int s, kk, nn, ll, mode;
        bit early;
        int exp_pulses, exp_pad;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int   p, a, m;
        sel = 1'b0; valid = 1'b0; cmd = C_CONF; din = 8'h00;
        eng_rdy = 1'b1; hf = 1'b0; hin = 8'h00;

        //          s  kk  nn   ll mode early pulses pad
        tbl[0] = '{0,  0, 32,   3, 0, 0,   64,  61};
        tbl[1] = '{0,  0,  4,   0, 2, 0,   64,  64};
        tbl[2] = '{1, 16,  8, 128, 0, 0,  256,   0};
        tbl[3] = '{0,  0,  2, 130, 1, 0,  192,  62};
        tbl[4] = '{0,  5,  1,  64, 2, 1,  128,   0};
        tbl[5] = '{1,  0,  3,   1, 1, 0,  128, 127};
        tbl[6] = '{1,  0,  5,   0, 0, 0,  128, 128};

        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = (s != 0);
            #1;
            chk("reset_data_v", dv_m, 0);
            chk("reset_ready", rdy_m, 0);
            chk("reset_hash_finished", hfo_m, 0);
            chk("reset_cfg", {kk_m, nn_m, ll_m}, 0);
            chk("reset_data", {d_m, h_m, idx_m, first_m, last_m}, 0);
        end
        @(negedge clk);
        nreset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_session(tbl[i].s, tbl[i].kk, tbl[i].nn, tbl[i].ll, tbl[i].mode, tbl[i].early,
                        0, 0, p, a, m);
            chk($sformatf("vec%0d_pulses", i), p, tbl[i].exp_pulses);
            chk($sformatf("vec%0d_pad", i), p - a, tbl[i].exp_pad);
        end

        run_session(0, 0, 4, 200, 0, 0, 1, 80, p, a, m);
        run_session(0, 0, 4, 10, 2, 0, 0, 0, p, a, m);
        chk("after_abort_pulses", p, 64);

        run_session(0, 7, 4, 20, 0, 0, 2, 0, p, a, m);
        run_session(1, 0, 2, 5, 0, 0, 0, 0, p, a, m);
        chk("after_reset_pulses", p, 128);

        for (int i = 0; i < 6; i++) begin
            int rs, rkk, rnn, rll, rmode;
            rs    = $urandom_range(0, 1);
            rkk   = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 32) : 0;
            rnn   = $urandom_range(1, 16);
            rll   = $urandom_range(0, 300);
            rmode = $urandom_range(0, 2);
            run_session(rs, rkk, rnn, rll, rmode, 0, 0, 0, p, a, m);
            chk($sformatf("rand%0d_pulses", i), p, m);
            chk($sformatf("rand%0d_accepted", i), a, rll + ((rkk != 0) ? (rs != 0 ? 128 : 64) : 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
